// File: rtl/argmax_sched_pkg.sv
// Shared types and sizing helpers for the chunked argmax scheduler.
package argmax_sched_pkg;

  // Default geometry: 32 elements of 8 bits, streamed as 8 chunks of 4.
  localparam int DEF_S = 5;
  localparam int DEF_M = 8;
  localparam int DEF_P = 2;

  // Scheduler control states; the encoding is fixed at 2 bits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of chunks needed to cover 2**s elements, 2**p at a time.
  function automatic int chunk_count(input int s, input int p);
    return 2 ** (s - p);
  endfunction

  // Width of the chunk counter; kept at least one bit for the single-chunk case.
  function automatic int cnt_width(input int s, input int p);
    return (s > p) ? (s - p) : 1;
  endfunction

  // Width of the in-chunk index; kept at least one bit for the bypass case.
  function automatic int cind_width(input int p);
    return (p > 0) ? p : 1;
  endfunction

  // Width of one chunk bus in bits.
  function automatic int chunk_bits(input int p, input int m);
    return (2 ** p) * m;
  endfunction

endpackage

// File: rtl/argmax_sched_argmax.sv
// Combinational argmax over 2**S unsigned M-bit values; ties go to the lowest index.
module argmax #(
  parameter int S = 2,
  parameter int M = 8
) (
  input  logic [(2**S)*M-1:0] i_data,
  output logic [M-1:0]        o_max,
  output logic [S-1:0]        o_ind
);

  localparam int N = 2 ** S;

  logic [M-1:0] w_elem [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_elem[gi] = i_data[gi*M +: M];
    end
  endgenerate

  // Linear scan with strict compare so the first occurrence of the maximum wins.
  always_comb begin
    o_max = w_elem[0];
    o_ind = '0;
    for (int k = 1; k < N; k++) begin
      if (w_elem[k] > o_max) begin
        o_max = w_elem[k];
        o_ind = S'(k);
      end
    end
  end

endmodule

// File: rtl/argmax_sched.sv
// Streams 2**S values as 2**(S-P) chunks through one shared argmax and keeps
// a running maximum plus its global index.
module argmax_sched
  import argmax_sched_pkg::*;
#(
  parameter int S = DEF_S,
  parameter int M = DEF_M,
  parameter int P = DEF_P
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(2**P)*M-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         max,
  output logic [S-1:0]         ind,
  output logic                 busy
);

  localparam int NCHUNK = chunk_count(S, P);
  localparam int CW     = cnt_width(S, P);
  localparam int CIW    = cind_width(P);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_first;
  logic [M-1:0]   r_max;
  logic [S-1:0]   r_ind;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [M-1:0]   w_cmax;
  logic [CIW-1:0] w_cind;
  logic [S-1:0]   w_cand_ind;

  // Chunk reduction: a single-element chunk needs no comparator at all.
  generate
    if (P == 0) begin : g_bypass
      assign w_cmax     = in_data;
      assign w_cind     = '0;
      assign w_cand_ind = r_cnt;
    end else begin : g_core
      argmax #(.S(P), .M(M)) u_argmax (
        .i_data (in_data),
        .o_max  (w_cmax),
        .o_ind  (w_cind)
      );
      if (P == S) begin : g_single
        assign w_cand_ind = w_cind;
      end else begin : g_multi
        assign w_cand_ind = {r_cnt, w_cind};
      end
    end
  endgenerate

  // Control FSM with the running max/index and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_max       <= '0;
      r_ind       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_max       <= '0;
      r_ind       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_first    <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            // Strict compare across chunks keeps the earlier chunk on ties.
            if (r_first || (w_cmax > r_max)) begin
              r_max <= w_cmax;
              r_ind <= w_cand_ind;
            end
            r_first <= 1'b0;
            r_cnt   <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign max       = r_max;
  assign ind       = r_ind;

endmodule

// File: tb/tb_argmax_sched.sv
// Directed and randomized checks for argmax_sched at S=5, M=8, P=2.
module tb_argmax_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  max_o;
  logic [4:0]  ind_o;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  argmax_sched #(.S(5), .M(8), .P(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max       (max_o),
    .ind       (ind_o),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] data;
    bit           bubbles;
    logic [7:0]   exp_max;
    logic [4:0]   exp_ind;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse start, then deliver nbeats chunks, optionally with random bubbles.
  task automatic feed(input logic [255:0] d, input bit bub, input int nbeats);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    for (int b = 0; b < nbeats; b++) begin
      while (bub && ($urandom_range(0, 1) == 0)) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        edges++;
        chk("in_ready_during_bubble", in_ready, 1);
      end
      in_valid = 1'b1;
      in_data  = d[b*32 +: 32];
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk); #1;
      edges++;
      g++;
    end
    chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 0);
  endtask

  logic [255:0] d;
  logic [7:0]   m_ref;
  logic [4:0]   i_ref;

  initial begin
    rst = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;

    // Vector table
    for (int i = 0; i < 32; i++) vecs[0].data[i*8 +: 8] = 8'(i);
    vecs[0].name = "distinct"; vecs[0].bubbles = 0; vecs[0].exp_max = 31; vecs[0].exp_ind = 31;
    for (int i = 0; i < 32; i++) vecs[1].data[i*8 +: 8] = (i == 9 || i == 22) ? 8'd200 : 8'd7;
    vecs[1].name = "mid_tie"; vecs[1].bubbles = 0; vecs[1].exp_max = 200; vecs[1].exp_ind = 9;
    for (int i = 0; i < 32; i++) vecs[2].data[i*8 +: 8] = 8'd50;
    vecs[2].name = "all_equal"; vecs[2].bubbles = 0; vecs[2].exp_max = 50; vecs[2].exp_ind = 0;
    for (int i = 0; i < 32; i++) vecs[3].data[i*8 +: 8] = 8'(31 - i);
    vecs[3].name = "descending"; vecs[3].bubbles = 1; vecs[3].exp_max = 31; vecs[3].exp_ind = 0;
    for (int i = 0; i < 32; i++) vecs[4].data[i*8 +: 8] = (i == 31) ? 8'd255 : 8'd254;
    vecs[4].name = "last_max"; vecs[4].bubbles = 0; vecs[4].exp_max = 255; vecs[4].exp_ind = 31;
    for (int i = 0; i < 32; i++) vecs[5].data[i*8 +: 8] = (i == 5 || i == 6) ? 8'd99 : 8'd1;
    vecs[5].name = "in_chunk_tie"; vecs[5].bubbles = 1; vecs[5].exp_max = 99; vecs[5].exp_ind = 5;

    // Reset state
    #23;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_max", max_o, 0);
    chk("rst_ind", ind_o, 0);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      feed(vecs[v].data, vecs[v].bubbles, 8);
      wait_done();
      if (!vecs[v].bubbles) chk({vecs[v].name, "_latency"}, edges + 1, 9);
      chk({vecs[v].name, "_max"}, max_o, vecs[v].exp_max);
      chk({vecs[v].name, "_ind"}, ind_o, vecs[v].exp_ind);
      $display("vec %s: max=%0d ind=%0d cycles=%0d", vecs[v].name, max_o, ind_o, edges + 1);
      handshake();
    end

    // Random values with random bubbles against a software reference
    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
      m_ref = d[7:0];
      i_ref = 0;
      for (int i = 1; i < 32; i++) begin
        if (d[i*8 +: 8] > m_ref) begin
          m_ref = d[i*8 +: 8];
          i_ref = 5'(i);
        end
      end
      feed(d, 1, 8);
      wait_done();
      chk("rand_max", max_o, m_ref);
      chk("rand_ind", ind_o, i_ref);
      $display("rand %0d: max=%0d ind=%0d ref_max=%0d ref_ind=%0d", r, max_o, ind_o, m_ref, i_ref);
      handshake();
    end

    // Output backpressure with start pulses during DONE
    feed(vecs[0].data, 0, 8);
    wait_done();
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_max", max_o, 31);
      chk("bp_ind", ind_o, 31);
      chk("bp_busy", busy, 0);
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    chk("bp_hs_out_valid", out_valid, 0);
    chk("bp_hs_busy", busy, 0);
    @(posedge clk); #1;
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_in_ready", in_ready, 0);
    $display("backpressure: held max=31 ind=31 for 5 cycles");

    // Clear after chunk 3 with a coincident beat
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'd100;
    feed(d, 0, 4);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_max", max_o, 0);
    chk("clr_ind", ind_o, 0);
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = (i == 30) ? 8'd255 : 8'(i % 20);
    feed(d, 0, 8);
    wait_done();
    chk("clr_run_max", max_o, 255);
    chk("clr_run_ind", ind_o, 30);
    $display("clear: rerun max=%0d ind=%0d", max_o, ind_o);
    handshake();

    // Asynchronous reset mid-run
    feed(d, 0, 3);
    chk("pre_rst_max", max_o, 11);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_max", max_o, 0);
    chk("arst_ind", ind_o, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    feed(vecs[1].data, 0, 8);
    wait_done();
    chk("post_rst_max", max_o, 200);
    chk("post_rst_ind", ind_o, 9);
    $display("reset: rerun max=%0d ind=%0d", max_o, ind_o);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argmax_sched.md
# argmax_sched

Sequential scheduler that computes the argmax of 2**S unsigned M-bit values by streaming them as 2**(S-P) chunks of 2**P values through one shared combinational `argmax` instance. It keeps a running maximum and global index. It sits between a chunked operand source and the result consumer, trading latency for gate count when the full-width combinational `argmax` is too large for a garbled-circuit netlist.

## Interface
- `S`, default 5: log2 of total element count (32 elements).
- `M`, default 8: element width in bits, unsigned.
- `P`, default 2: log2 of elements per chunk; 0 ≤ P ≤ S.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a new search; sampled in IDLE only.
- `clear` input 1: synchronous abort to IDLE; priority over all other inputs.
- `in_valid` input 1: chunk on `in_data` is valid.
- `in_ready` output 1: scheduler accepts a chunk this cycle.
- `in_data` input (2**P)*M: chunk; element k occupies bits [(k+1)*M-1 : k*M].
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `max` output M: maximum value.
- `ind` output S: global index of `max`.
- `busy` output 1: high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. Clears chunk counter `cnt` (S-P bits) and the first-beat flag.
  - RUN: `in_ready` = 1. A beat is `in_valid & in_ready`.
    - On each beat the sub-module yields `cmax`/`cind` (P bits).
    - On the first beat, or when `cmax > max` (strict), update `max <= cmax` and `ind <= {cnt, cind}`.
    - `cnt` increments on every beat. The beat with `cnt == 2**(S-P)-1` moves to DONE.
  - DONE: `out_valid` = 1. `max`/`ind` are held stable until `out_valid & out_ready`, then the FSM returns to IDLE.
- Ties resolve to the lowest global index:
  - Within a chunk, the sub-module returns the lowest index.
  - Across chunks, strict `>` keeps the earlier chunk's index.
- `start` outside IDLE is ignored. `start` in the same cycle as `out_ready` handshake is also ignored; the block returns to IDLE first.
- `clear` in any state: the next state is IDLE, `max`/`ind` return to 0, and a coincident beat is dropped.
- P == S degenerates to a single-beat run.
- Reset values: state IDLE, `cnt` 0, `max` 0, `ind` 0, `in_ready` 0, `out_valid` 0, `busy` 0.

## Timing
- `in_ready`, `out_valid` and `busy` are Moore outputs decoded from registered state. There is no combinational path from `in_valid` or `out_ready` to any output.
- `max`/`ind` are registered; they update on the edge ending each accepted beat.
- Latency:
  - `start` edge → `in_ready` high next cycle.
  - Last beat edge → `out_valid` high next cycle.
  - Minimum from `start` to `out_valid` is 1 + 2**(S-P) cycles.
- Back-to-back beats are supported at one chunk per cycle. Bubbles (`in_valid` = 0) stall `cnt` without limit.
- Asynchronous reset mid-RUN discards all progress; outputs go to reset values immediately.

## Structure
- The shared package holds:
  - element-width and index-width helper constants;
  - the FSM state enum (IDLE=0, RUN=1, DONE=2, 2-bit encoding);
  - the chunk-count expression 2**(S-P).
- The existing combinational `argmax` is instantiated once with `.S(P)`, `.M(M)` on `in_data`. No other sub-module.
- The P == 0 case needs a generate branch: bypass the sub-module, with `cmax = in_data` and `cind` of zero width.

## Test plan
(All scenarios use S=5, M=8, P=2, i.e. 8 chunks.)
- Distinct values: element i = i, streamed back-to-back → `out_valid` at cycle 9 after `start`, `max`=31, `ind`=31.
- Max in the middle with ties: all elements 7 except elements 9 and 22 = 200 → `max`=200, `ind`=9 (earlier wins). Variant with all elements equal 50 → `ind`=0.
- Random bubbles: `in_valid` toggled at a 50% random rate over 100 runs of random values 0..255 → `max`/`ind` match a software reference, and `cnt` never advances on idle cycles.
- Output backpressure: `out_ready` held low for 5 cycles in DONE → `max`/`ind`/`out_valid` stable. Pulsing `start` during DONE has no effect.
- `clear` after chunk 3, then a new `start` with element 30 = 255 → first run discarded, result `max`=255, `ind`=30.
- `rst` asserted mid-RUN (asynchronous, between edges) → all outputs 0 immediately. After release, a fresh run produces a correct result.
